// File: rtl/mem_wb_stage.sv
// mem_wb_stage -- MEM/WB pipeline stage built as a two-entry skid buffer.
//
// Formats loads from data memory (little-endian lane select plus sign or zero
// extension) or passes the ALU result through. The result is registered, so an
// accepted entry appears on the write-back outputs one cycle after acceptance.
// InReadyM comes from registered state only, so there is no combinational path
// from OutReadyW back to the memory stage.
//
// Optional feature: define MEM_WB_STALL_CNT_EN to build the back-pressure
// counter. Without it, StallCountW is tied to zero and the port is kept.
//
// Ports
//   Clk, Reset         clock; asynchronous active-low reset
//   InValidM/InReadyM  memory-stage handshake
//   ReadDataM          raw word read from data memory
//   AddressM           ALU result / effective address
//   MemTypeM           00 word, 01 half, 10 byte, 11 reserved (treated as word)
//   LoadUnsignedM      1 = zero-extend, 0 = sign-extend
//   MemToRegM          1 = result from memory, 0 = AddressM
//   RegWriteM/WriteRegM destination control
//   FlushW             discard every held entry
//   OutValidW/OutReadyW write-back handshake
//   ResultW/WriteRegW/RegWriteW write-back payload
//   StallCountW        saturating count of cycles with OutValidW=1, OutReadyW=0

package mem_wb_stage_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned CNT_W   = 16;

    localparam logic [1:0] MT_WORD = 2'b00;
    localparam logic [1:0] MT_HALF = 2'b01;
    localparam logic [1:0] MT_BYTE = 2'b10;

    // One buffered write-back entry.
    typedef struct packed {
        logic [XLEN-1:0]   result;
        logic [REG_AW-1:0] wreg;
        logic              regwrite;
    } wb_entry_t;

endpackage

module mem_wb_stage
    import mem_wb_stage_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValidM,
    output logic              InReadyM,
    input  logic [XLEN-1:0]   ReadDataM,
    input  logic [XLEN-1:0]   AddressM,
    input  logic [1:0]        MemTypeM,
    input  logic              LoadUnsignedM,
    input  logic              MemToRegM,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic              FlushW,
    output logic              OutValidW,
    input  logic              OutReadyW,
    output logic [XLEN-1:0]   ResultW,
    output logic [REG_AW-1:0] WriteRegW,
    output logic              RegWriteW,
    output logic [CNT_W-1:0]  StallCountW
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    state_e    state_q, state_d;
    wb_entry_t main_q, main_d;
    wb_entry_t skid_q, skid_d;
    logic      in_ready_q, in_ready_d;
    logic      out_valid_q, out_valid_d;

    logic      accept;
    logic      transfer;
    wb_entry_t incoming;

    // Little-endian load formatting; the reserved type behaves as a word load.
    function automatic logic [XLEN-1:0] load_format(
        input logic [XLEN-1:0] data,
        input logic [1:0]      lane,
        input logic [1:0]      mem_type,
        input logic            unsigned_ld
    );
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        case (lane)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        // Halfword lane ignores address bit 0.
        h = lane[1] ? data[31:16] : data[15:0];
        case (mem_type)
            MT_BYTE: r = unsigned_ld ? {24'd0, b} : {{24{b[7]}}, b};
            MT_HALF: r = unsigned_ld ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = data;
        endcase
        return r;
    endfunction

    assign accept   = InValidM && in_ready_q;
    assign transfer = out_valid_q && OutReadyW;

    // Result is resolved before it is buffered.
    always_comb begin
        incoming.result   = MemToRegM
                          ? load_format(ReadDataM, AddressM[1:0], MemTypeM, LoadUnsignedM)
                          : AddressM;
        incoming.wreg     = WriteRegM;
        incoming.regwrite = RegWriteM;
    end

    // Next-state and buffer update.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = incoming;
                end
            end
            ST_ONE: begin
                case ({accept, transfer})
                    2'b10: begin
                        state_d = ST_FULL;
                        skid_d  = incoming;
                    end
                    2'b11: main_d  = incoming;
                    2'b01: state_d = ST_EMPTY;
                    default: ;
                endcase
            end
            ST_FULL: begin
                // InReadyM is low here, so only a transfer can occur.
                if (transfer) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush wins over any simultaneous accept or transfer.
        if (FlushW) begin
            state_d = ST_EMPTY;
        end

        // An empty stage never presents a register write.
        if (state_d == ST_EMPTY) begin
            main_d.regwrite = 1'b0;
        end

        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State and payload registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign InReadyM  = in_ready_q;
    assign OutValidW = out_valid_q;
    assign ResultW   = main_q.result;
    assign WriteRegW = main_q.wreg;
    assign RegWriteW = main_q.regwrite;

`ifdef MEM_WB_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating back-pressure counter; flush leaves it untouched.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !OutReadyW && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCountW = stall_cnt_q;
`else
    assign StallCountW = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage with a queue-based reference model,
// per-cycle output comparison and a few hand-computed directed cases.
module tb_mem_wb_stage;

`ifdef MEM_WB_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        Clk;
    logic        Reset;
    logic        InValidM;
    logic        InReadyM;
    logic [31:0] ReadDataM;
    logic [31:0] AddressM;
    logic [1:0]  MemTypeM;
    logic        LoadUnsignedM;
    logic        MemToRegM;
    logic        RegWriteM;
    logic [4:0]  WriteRegM;
    logic        FlushW;
    logic        OutValidW;
    logic        OutReadyW;
    logic [31:0] ResultW;
    logic [4:0]  WriteRegW;
    logic        RegWriteW;
    logic [15:0] StallCountW;

    mem_wb_stage dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .InValidM     (InValidM),
        .InReadyM     (InReadyM),
        .ReadDataM    (ReadDataM),
        .AddressM     (AddressM),
        .MemTypeM     (MemTypeM),
        .LoadUnsignedM(LoadUnsignedM),
        .MemToRegM    (MemToRegM),
        .RegWriteM    (RegWriteM),
        .WriteRegM    (WriteRegM),
        .FlushW       (FlushW),
        .OutValidW    (OutValidW),
        .OutReadyW    (OutReadyW),
        .ResultW      (ResultW),
        .WriteRegW    (WriteRegW),
        .RegWriteW    (RegWriteW),
        .StallCountW  (StallCountW)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] res;
        logic [4:0]  wr;
        logic        rw;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_stall  = 0;
    bit          m_rw_zero = 1'b1;

    function automatic logic [31:0] exp_result(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [1:0] mt, input logic uns, input logic m2r);
        int unsigned sh;
        logic [31:0] v;
        if (!m2r) return addr;
        if (mt == 2'b10) begin
            sh = (addr % 4) * 8;
            v  = (data >> sh) & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
            return v;
        end
        if (mt == 2'b01) begin
            sh = ((addr / 2) % 2) * 16;
            v  = (data >> sh) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
            return v;
        end
        return data;
    endfunction

    always @(posedge Clk or negedge Reset) begin
        bit   acc, xfer;
        ent_t e;
        if (!Reset) begin
            mq.delete();
            m_stall   = 0;
            m_rw_zero = 1'b1;
        end else begin
            acc  = InValidM && (mq.size() < 2);
            xfer = (mq.size() > 0) && OutReadyW;
            if (CNT_EN && (mq.size() > 0) && !OutReadyW && m_stall < 65535) m_stall++;
            if (FlushW) begin
                mq.delete();
                m_rw_zero = 1'b1;
            end else begin
                if (xfer) void'(mq.pop_front());
                if (acc) begin
                    e.res = exp_result(AddressM, ReadDataM, MemTypeM, LoadUnsignedM, MemToRegM);
                    e.wr  = WriteRegM;
                    e.rw  = RegWriteM;
                    mq.push_back(e);
                    m_rw_zero = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge Clk) begin
        if (!Reset) begin
            chk("rst_out_valid", 32'(OutValidW), 32'd0);
            chk("rst_result",    ResultW, 32'd0);
            chk("rst_wreg",      32'(WriteRegW), 32'd0);
            chk("rst_regwrite",  32'(RegWriteW), 32'd0);
            chk("rst_stall",     32'(StallCountW), 32'd0);
        end else begin
            chk("in_ready",  32'(InReadyM),  32'(mq.size() < 2));
            chk("out_valid", 32'(OutValidW), 32'(mq.size() > 0));
            chk("stall_cnt", 32'(StallCountW), 32'(m_stall));
            if (mq.size() > 0) begin
                chk("result",   ResultW, mq[0].res);
                chk("wreg",     32'(WriteRegW), 32'(mq[0].wr));
                chk("regwrite", 32'(RegWriteW), 32'(mq[0].rw));
            end else if (m_rw_zero) begin
                chk("regwrite_cleared", 32'(RegWriteW), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] mt, input logic uns, input logic m2r,
                         input logic [4:0] wr, input logic ordy, input logic fl);
        InValidM      = v;
        AddressM      = addr;
        ReadDataM     = data;
        MemTypeM      = mt;
        LoadUnsignedM = uns;
        MemToRegM     = m2r;
        RegWriteM     = 1'b1;
        WriteRegM     = wr;
        OutReadyW     = ordy;
        FlushW        = fl;
    endtask

    // Reset pulse asserted between edges, released away from an edge.
    task automatic async_reset();
        @(posedge Clk);
        #2 Reset = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(OutValidW), 32'd0);
        chk("async_rst_stall",     32'(StallCountW), 32'd0);
        @(negedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        chk("post_rst_in_ready", 32'(InReadyM), 32'd1);
    endtask

    initial begin
        Reset = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        RegWriteM = 1'b0;
        repeat (3) @(negedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        chk("init_in_ready",  32'(InReadyM), 32'd1);
        chk("init_out_valid", 32'(OutValidW), 32'd0);

        // Signed byte load from lane 3.
        drive(1'b1, 32'h00000003, 32'h80FF1234, 2'b10, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
        @(negedge Clk);
        chk("lit_sbyte", ResultW, 32'hFFFFFF80);
        chk("lit_sbyte_valid", 32'(OutValidW), 32'd1);
        // Unsigned halfword load, accepted while the previous entry leaves.
        drive(1'b1, 32'h00000002, 32'hBEEF0011, 2'b01, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        @(negedge Clk);
        chk("lit_uhalf", ResultW, 32'h0000BEEF);
        // ALU pass-through.
        drive(1'b1, 32'h12345678, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        @(negedge Clk);
        chk("lit_alu_result", ResultW, 32'h12345678);
        chk("lit_alu_wreg", 32'(WriteRegW), 32'd5);
        drive(1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        @(negedge Clk);
        chk("drain_empty", 32'(OutValidW), 32'd0);

        // Back-pressure: two accepts with OutReadyW low.
        drive(1'b1, 32'hAAAA0001, 32'd0, 2'b00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0);
        @(negedge Clk);
        drive(1'b1, 32'hBBBB0002, 32'd0, 2'b00, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0);
        @(negedge Clk);
        chk("bp_in_ready_low", 32'(InReadyM), 32'd0);
        drive(1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge Clk);
        chk("bp_stall_two", 32'(StallCountW), CNT_EN ? 32'd2 : 32'd0);
        chk("bp_first_out", ResultW, 32'hAAAA0001);
        OutReadyW = 1'b1;
        @(negedge Clk);
        chk("bp_second_out", ResultW, 32'hBBBB0002);
        chk("bp_in_ready_back", 32'(InReadyM), 32'd1);
        @(negedge Clk);
        chk("bp_drained", 32'(OutValidW), 32'd0);

        // Flush from FULL with a simultaneous valid input.
        drive(1'b1, 32'h00000C01, 32'd0, 2'b00, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0);
        @(negedge Clk);
        drive(1'b1, 32'h00000D02, 32'd0, 2'b00, 1'b0, 1'b0, 5'd4, 1'b0, 1'b0);
        @(negedge Clk);
        drive(1'b1, 32'h00000E03, 32'd0, 2'b00, 1'b0, 1'b0, 5'd6, 1'b0, 1'b1);
        @(negedge Clk);
        chk("flush_empty", 32'(OutValidW), 32'd0);
        chk("flush_regwrite", 32'(RegWriteW), 32'd0);
        drive(1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        @(negedge Clk);
        chk("flush_dropped", 32'(OutValidW), 32'd0);

        // Asynchronous reset while holding one entry.
        drive(1'b1, 32'h0000F00D, 32'd0, 2'b00, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0);
        @(negedge Clk);
        chk("pre_rst_one", 32'(OutValidW), 32'd1);
        InValidM = 1'b0;
        async_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) async_reset();
            InValidM      = ($urandom_range(0, 3) != 0);
            ReadDataM     = $urandom;
            AddressM      = $urandom;
            MemTypeM      = 2'($urandom_range(0, 3));
            LoadUnsignedM = 1'($urandom_range(0, 1));
            MemToRegM     = ($urandom_range(0, 3) != 0);
            RegWriteM     = 1'($urandom_range(0, 1));
            WriteRegM     = 5'($urandom);
            OutReadyW     = ($urandom_range(0, 9) < 6);
            FlushW        = ($urandom_range(0, 19) == 0);
            @(negedge Clk);
        end

        drive(1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        repeat (3) @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
